bnn_output_collector: RTL

- Downstream stage of the single-bit BNN neuron.
- Serially captures the neuron's binary output (one bit per accepted beat) into an N_OUT-wide activation vector.
- Keeps a running popcount and applies a threshold activation.
- Presents the packed frame to the next layer through a valid/ready handshake, with backpressure to the neuron sequencer.

---
 rtl/bnn_pkg.sv | 26 ++
 rtl/bnn_output_collector.sv | 115 +++++++++++
 2 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN output collector.
//   state_t     : collector FSM states (COLLECT, HOLD)
//   N_OUT_DEF   : default frame width in bits
//   THRESH_DEF  : default activation threshold
//   clog2_w()   : ceiling log2, used to size the bit counter and popcount
package bnn_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   localparam int N_OUT_DEF  = 8;
   localparam int THRESH_DEF = 4;

   // Smallest r such that 2**r >= v. Returns 0 for v <= 1.
   function automatic int clog2_w(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bnn_output_collector.sv
// bnn_output_collector
// Serially packs the single-bit neuron output into an N_OUT-wide frame,
// keeps an incremental popcount and drives a threshold activation. The
// finished frame is held behind a valid/ready handshake; while it is held
// the upstream neuron sequencer is backpressured via in_ready.
//
// Ports
//   clk           clock, all state on rising edge
//   rst           synchronous active-high reset
//   in_valid      neuron bit valid
//   in_bit        neuron bit
//   in_last       closes a short frame (qualified by in_valid)
//   in_ready      collector can accept a bit
//   out_valid     frame available
//   out_ready     downstream accepts the frame
//   out_vec       packed frame, bit i = i-th accepted bit
//   out_popcount  number of ones in out_vec
//   out_act       out_popcount >= THRESH
//   frame_count   completed-frame counter
//
// Build option
//   BNN_COLLECT_STATS_EN : when defined, frame_count is a 16-bit wrapping
//                          counter of output handshakes; otherwise it is
//                          tied to zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accepting bits; in_ready=1, out_valid=0
// HOLD    | frame complete and presented; in_ready=0, out_valid=1
module bnn_output_collector
   import bnn_pkg::*;
#(
   parameter  int N_OUT  = N_OUT_DEF,
   parameter  int THRESH = THRESH_DEF,
   localparam int CNT_W  = clog2_w(N_OUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_bit,
   input  logic              in_last,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_OUT-1:0]  out_vec,
   output logic [CNT_W-1:0]  out_popcount,
   output logic              out_act,
   output logic [15:0]       frame_count
);

   localparam logic [0:0] ST_COLLECT = 1'(COLLECT);
   localparam logic [0:0] ST_HOLD    = 1'(HOLD);

   logic [0:0]       r_state;
   logic [N_OUT-1:0] r_vec;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_popcount;

   logic w_accept;
   logic w_close;
   logic w_xfer;

   assign w_accept = (r_state == ST_COLLECT) && in_valid;
   // The accepted bit fills the frame, or upstream marks it as the last one.
   // Both conditions together still close the frame only once.
   assign w_close  = w_accept && ((r_count == CNT_W'(N_OUT - 1)) || in_last);
   assign w_xfer   = (r_state == ST_HOLD) && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_COLLECT;
         r_vec      <= '0;
         r_count    <= '0;
         r_popcount <= '0;
      end else begin
         if (w_accept) begin
            // Decoded write avoids an index wider than the vector.
            for (int i = 0; i < N_OUT; i++) begin
               if (r_count == CNT_W'(i)) r_vec[i] <= in_bit;
            end
            r_count    <= r_count + CNT_W'(1);
            r_popcount <= r_popcount + CNT_W'(in_bit);
            if (w_close) r_state <= ST_HOLD;
         end else if (w_xfer) begin
            r_vec      <= '0;
            r_count    <= '0;
            r_popcount <= '0;
            r_state    <= ST_COLLECT;
         end
      end
   end

   assign in_ready     = (r_state == ST_COLLECT);
   assign out_valid    = (r_state == ST_HOLD);
   assign out_vec      = r_vec;
   assign out_popcount = r_popcount;
   assign out_act      = (r_popcount >= CNT_W'(THRESH));

`ifdef BNN_COLLECT_STATS_EN
   logic [15:0] r_frame_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_count <= '0;
      end else if (w_xfer) begin
         r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign frame_count = r_frame_count;
`else
   assign frame_count = 16'd0;
`endif

endmodule
